// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard: architectural register constants
// and the issue-control FSM state encoding.
package issue_scoreboard_pkg;

  localparam int unsigned NumRegs      = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StDrain = 2'd2
  } sb_state_e;

endpackage

// File: rtl/issue_scoreboard_pend_counter.sv
// Outstanding-write counter for one architectural register.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   inc_i         : a write to this register was issued
//   dec_i         : a writeback to this register completed
//   cnt_o         : current outstanding-write count
//   underflow_o   : dec_i arrived while the count was already zero (dec ignored)
module issue_scoreboard_pend_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             underflow_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             empty, full, dec_ok;

  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == '1);
    dec_ok = dec_i & ~empty;
    cnt_d  = cnt_q;
    // inc and a real dec cancel; a dec on an empty counter is dropped.
    if (inc_i && dec_ok) begin
      cnt_d = cnt_q;
    end else if (inc_i && !full) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_ok) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign underflow_o = dec_i & empty;

endmodule

// File: rtl/issue_scoreboard.sv
// Register-hazard scoreboard and issue controller between decode and execute.
//   clk, reset            : clock, asynchronous active-low reset
//   dec_*                 : decoded uop and its register fields with valid qualifiers
//   system_stall          : downstream back-pressure, blocks issue
//   wb_valid, wb_rd       : writeback completion
//   flush                 : redirect pulse, enters DRAIN until no writes are outstanding
//   stall_cnt_clr         : synchronous clear of stall_cycles
//   source_not_ready      : combinational hold back to decode
//   issue                 : combinational uop acceptance
//   busy_vec              : per-register "write outstanding" flags
//   drained               : one-cycle pulse after leaving DRAIN
//   wb_underflow          : sticky flag, writeback with nothing outstanding
//   stall_cycles          : saturating count of hazard-stall cycles
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS        = NumRegs,
  parameter int unsigned REG_ADDR_WIDTH  = RegAddrWidth,
  parameter int unsigned PEND_WIDTH      = 2,
  parameter bit          WB_BYPASS       = 1'b1,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dec_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_rd,
  input  logic                       dec_rs1_valid,
  input  logic                       dec_rs2_valid,
  input  logic                       dec_rd_valid,
  input  logic                       system_stall,
  input  logic                       wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
  input  logic                       flush,
  input  logic                       stall_cnt_clr,
  output logic                       source_not_ready,
  output logic                       issue,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic                       drained,
  output logic                       wb_underflow,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [PEND_WIDTH-1:0] PendOne = PEND_WIDTH'(1);

  logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend;
  logic [NUM_REGS-1:1]                 underflow_vec;

  sb_state_e                  state_q, state_d;
  logic                       drained_q, drained_d;
  logic                       wb_underflow_q, wb_underflow_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       rs1_haz, rs2_haz, sat_haz;

  // x0 is hardwired idle.
  assign pend[0] = '0;

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_pend
    localparam logic [REG_ADDR_WIDTH-1:0] Idx = REG_ADDR_WIDTH'(i);
    issue_scoreboard_pend_counter #(
      .Width(PEND_WIDTH)
    ) u_cnt (
      .clk_i      (clk),
      .rst_ni     (reset),
      .inc_i      (issue & dec_rd_valid & (dec_rd == Idx)),
      .dec_i      (wb_valid & (wb_rd == Idx)),
      .cnt_o      (pend[i]),
      .underflow_o(underflow_vec[i])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (pend[i] != '0);
    end
  end

  // A writeback retiring the last outstanding write releases the reader in the same cycle.
  always_comb begin
    rs1_haz = dec_rs1_valid && (pend[dec_rs1] != '0);
    rs2_haz = dec_rs2_valid && (pend[dec_rs2] != '0);
    if (WB_BYPASS && wb_valid && (wb_rd == dec_rs1) && (pend[dec_rs1] == PendOne)) begin
      rs1_haz = 1'b0;
    end
    if (WB_BYPASS && wb_valid && (wb_rd == dec_rs2) && (pend[dec_rs2] == PendOne)) begin
      rs2_haz = 1'b0;
    end
    sat_haz = dec_rd_valid && (dec_rd != '0) && (pend[dec_rd] == '1);
  end

  assign source_not_ready = dec_valid & (rs1_haz | rs2_haz | sat_haz | (state_q == StDrain));
  assign issue            = dec_valid & ~source_not_ready & ~system_stall;

  always_comb begin
    state_d   = state_q;
    drained_d = 1'b0;
    case (state_q)
      StRun, StHold: state_d = source_not_ready ? StHold : StRun;
      StDrain: begin
        if (busy_vec == '0) begin
          state_d   = StRun;
          drained_d = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
    if (flush) begin
      state_d   = StDrain;
      drained_d = 1'b0;
    end

    wb_underflow_d = wb_underflow_q | (|underflow_vec);

    stall_d = stall_q;
    if (stall_cnt_clr) begin
      stall_d = '0;
    end else if (source_not_ready && !(&stall_q)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StRun;
      drained_q      <= 1'b0;
      wb_underflow_q <= 1'b0;
      stall_q        <= '0;
    end else begin
      state_q        <= state_d;
      drained_q      <= drained_d;
      wb_underflow_q <= wb_underflow_d;
      stall_q        <= stall_d;
    end
  end

  assign drained      = drained_q;
  assign wb_underflow = wb_underflow_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: a vector table for single-cycle behaviour
// plus hand sequences for underflow, flush/drain, the stall counter and async reset.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_rs1_valid, dec_rs2_valid, dec_rd_valid;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        system_stall, wb_valid, flush, stall_cnt_clr;
  logic        source_not_ready, issue, drained, wb_underflow;
  logic [31:0] busy_vec;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard dut (
    .clk             (clk),
    .reset           (reset),
    .dec_valid       (dec_valid),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_rd          (dec_rd),
    .dec_rs1_valid   (dec_rs1_valid),
    .dec_rs2_valid   (dec_rs2_valid),
    .dec_rd_valid    (dec_rd_valid),
    .system_stall    (system_stall),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .flush           (flush),
    .stall_cnt_clr   (stall_cnt_clr),
    .source_not_ready(source_not_ready),
    .issue           (issue),
    .busy_vec        (busy_vec),
    .drained         (drained),
    .wb_underflow    (wb_underflow),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic        rs1v;
    logic [4:0]  rs2;
    logic        rs2v;
    logic [4:0]  rd;
    logic        rdv;
    logic        ss;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        exp_snr;
    logic        exp_iss;
    logic [31:0] exp_busy;
  } vec_t;

  typedef struct {
    logic        snr;
    logic        iss;
    logic [31:0] busy;
  } exp_t;

  vec_t vecs[24];
  exp_t exp_q[$];

  function automatic vec_t mk(logic dv, logic [4:0] rs1, logic rs1v, logic [4:0] rs2,
                              logic rs2v, logic [4:0] rd, logic rdv, logic ss, logic wbv,
                              logic [4:0] wbrd, logic esnr, logic eiss, logic [31:0] ebusy);
    vec_t v;
    v.dv = dv;   v.rs1 = rs1; v.rs1v = rs1v; v.rs2 = rs2; v.rs2v = rs2v;
    v.rd = rd;   v.rdv = rdv; v.ss = ss;     v.wbv = wbv; v.wbrd = wbrd;
    v.exp_snr = esnr; v.exp_iss = eiss; v.exp_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    dec_valid     = v.dv;
    dec_rs1       = v.rs1;
    dec_rs1_valid = v.rs1v;
    dec_rs2       = v.rs2;
    dec_rs2_valid = v.rs2v;
    dec_rd        = v.rd;
    dec_rd_valid  = v.rdv;
    system_stall  = v.ss;
    wb_valid      = v.wbv;
    wb_rd         = v.wbrd;
    flush         = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shorthands: a uop writing rd, a uop reading rs1, a bare writeback, idle.
  function automatic vec_t uop_wr(logic [4:0] rd);
    return mk(1, 0, 0, 0, 0, rd, 1, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t uop_rd(logic [4:0] rs);
    return mk(1, rs, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t wb_only(logic [4:0] r);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1, r, 0, 0, 0);
  endfunction

  initial begin
    exp_t e;
    vec_t v;

    //         dv rs1 v  rs2 v  rd v  ss wb wbrd  snr iss busy
    vecs[0]  = mk(0, 0, 0,  0, 0,  0, 0, 0, 0, 0,   0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 0,  0, 0,  5, 1, 0, 0, 0,   0, 1, 32'h20);
    vecs[2]  = mk(1, 5, 1,  0, 0,  0, 0, 0, 0, 0,   1, 0, 32'h20);
    vecs[3]  = mk(1, 5, 1,  0, 0,  0, 0, 0, 1, 5,   0, 1, 32'h0);
    vecs[4]  = mk(1, 0, 0,  0, 0,  0, 1, 0, 0, 0,   0, 1, 32'h0);
    vecs[5]  = mk(1, 0, 1,  0, 1,  0, 0, 0, 0, 0,   0, 1, 32'h0);
    vecs[6]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,   0, 1, 32'h80);
    vecs[7]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,   0, 1, 32'h80);
    vecs[8]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,   0, 1, 32'h80);
    vecs[9]  = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,   1, 0, 32'h80);
    vecs[10] = mk(1, 0, 0,  0, 0,  7, 1, 0, 1, 7,   1, 0, 32'h80);
    vecs[11] = mk(1, 0, 0,  0, 0,  7, 1, 0, 0, 0,   0, 1, 32'h80);
    vecs[12] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 7,   0, 0, 32'h80);
    vecs[13] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 7,   0, 0, 32'h80);
    vecs[14] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 7,   0, 0, 32'h0);
    vecs[15] = mk(1, 0, 0,  0, 0,  9, 1, 0, 0, 0,   0, 1, 32'h200);
    vecs[16] = mk(1, 0, 0,  0, 0,  9, 1, 0, 1, 9,   0, 1, 32'h200);
    vecs[17] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 9,   0, 0, 32'h0);
    vecs[18] = mk(1, 0, 0,  0, 0, 10, 1, 1, 0, 0,   0, 0, 32'h0);
    vecs[19] = mk(1, 0, 0,  0, 0, 11, 1, 0, 0, 0,   0, 1, 32'h800);
    vecs[20] = mk(1, 11, 0, 11, 1, 0, 0, 0, 0, 0,   1, 0, 32'h800);
    vecs[21] = mk(1, 11, 0, 11, 0, 0, 0, 0, 0, 0,   0, 1, 32'h800);
    vecs[22] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 11,  0, 0, 32'h0);
    vecs[23] = mk(1, 11, 1, 0, 0,  0, 0, 0, 0, 0,   0, 1, 32'h0);

    reset = 1'b0;
    stall_cnt_clr = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_drained", {31'h0, drained}, 32'h0);
    chk("reset_wb_underflow", {31'h0, wb_underflow}, 32'h0);
    chk("reset_stall_cycles", {16'h0, stall_cycles}, 32'h0);
    chk("reset_snr", {31'h0, source_not_ready}, 32'h0);
    chk("reset_issue", {31'h0, issue}, 32'h0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i]);
      exp_q.push_back('{snr: vecs[i].exp_snr, iss: vecs[i].exp_iss, busy: vecs[i].exp_busy});
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("vec%0d_snr", i), {31'h0, source_not_ready}, {31'h0, e.snr});
      chk($sformatf("vec%0d_issue", i), {31'h0, issue}, {31'h0, e.iss});
      step();
      chk($sformatf("vec%0d_busy", i), busy_vec, e.busy);
    end
    // Hazard-stall cycles in the table: vectors 2, 9, 10 and 20.
    chk("table_stall_cycles", {16'h0, stall_cycles}, 32'd4);
    chk("table_no_underflow", {31'h0, wb_underflow}, 32'h0);

    // Writeback to an idle register is flagged and the flag is sticky.
    drive(wb_only(12));
    step();
    chk("underflow_set", {31'h0, wb_underflow}, 32'h1);
    chk("underflow_busy", busy_vec, 32'h0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    chk("underflow_sticky", {31'h0, wb_underflow}, 32'h1);

    // Flush with pend[3]=1, pend[4]=2; issue in the flush cycle still counts.
    drive(uop_wr(3));
    step();
    drive(uop_wr(4));
    step();
    drive(uop_wr(4));
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_issue", {31'h0, issue}, 32'h1);
    step();
    chk("flush_busy", busy_vec, 32'h18);
    for (int k = 0; k < 3; k++) begin
      v = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, (k == 0) ? 5'd3 : 5'd4, 0, 0, 0);
      drive(v);
      @(negedge clk);
      chk($sformatf("drain_wb%0d_snr", k), {31'h0, source_not_ready}, 32'h1);
      chk($sformatf("drain_wb%0d_issue", k), {31'h0, issue}, 32'h0);
      step();
      chk($sformatf("drain_wb%0d_drained", k), {31'h0, drained}, 32'h0);
    end
    chk("drain_busy_clear", busy_vec, 32'h0);
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("drain_exit_cycle_snr", {31'h0, source_not_ready}, 32'h1);
    step();
    chk("drained_pulse", {31'h0, drained}, 32'h1);
    @(negedge clk);
    chk("run_after_drain_snr", {31'h0, source_not_ready}, 32'h0);
    chk("run_after_drain_issue", {31'h0, issue}, 32'h1);
    step();
    chk("drained_single", {31'h0, drained}, 32'h0);

    // Stall counter: clear, count a 10-cycle RAW stall, clear wins over increment.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    chk("stall_clr_idle", {16'h0, stall_cycles}, 32'h0);
    drive(uop_wr(6));
    step();
    drive(uop_rd(6));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("raw_stall%0d_snr", k), {31'h0, source_not_ready}, 32'h1);
      step();
    end
    chk("stall_cycles_10", {16'h0, stall_cycles}, 32'd10);
    stall_cnt_clr = 1'b1;
    step();
    stall_cnt_clr = 1'b0;
    chk("stall_clr_priority", {16'h0, stall_cycles}, 32'h0);
    step();
    chk("stall_after_clr", {16'h0, stall_cycles}, 32'h1);

    // Asynchronous reset in the middle of the stall.
    #2 reset = 1'b0;
    #1;
    chk("async_busy", busy_vec, 32'h0);
    chk("async_stall", {16'h0, stall_cycles}, 32'h0);
    chk("async_underflow", {31'h0, wb_underflow}, 32'h0);
    chk("async_drained", {31'h0, drained}, 32'h0);
    chk("async_snr", {31'h0, source_not_ready}, 32'h0);
    step();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Register-hazard scoreboard and issue controller that sits between the decode stage and the execution unit. It tracks outstanding writes to each architectural register, compares each decoded uop's sources and destination against them, and drives `source_not_ready` back into decode so the uop is held and re-dispatched. It also accepts writeback completions, sequences a drain after a pipeline flush, and keeps a saturating hazard-stall cycle counter.

## Interface
- `NUM_REGS`, 32: architectural register count.
- `REG_ADDR_WIDTH`, 5: register address width, equal to clog2(`NUM_REGS`).
- `PEND_WIDTH`, 2: width of the per-register outstanding-write counter. Maximum is 2^`PEND_WIDTH`-1.
- `WB_BYPASS`, 1: when 1, a same-cycle writeback that retires the last pending write clears the hazard combinationally.
- `STALL_CNT_WIDTH`, 16: width of the stall statistics counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `dec_valid`  in  1  decoded uop present; this is the uop-valid output of decode.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  `REG_ADDR_WIDTH` each  decoded register addresses.
- `dec_rs1_valid`, `dec_rs2_valid`, `dec_rd_valid`  in  1 each  field-used qualifiers.
- `system_stall`  in  1  downstream back-pressure; while high, no issue occurs.
- `wb_valid`  in  1  writeback completing this cycle.
- `wb_rd`  in  `REG_ADDR_WIDTH`  writeback destination.
- `flush`  in  1  redirect request, a single-cycle pulse.
- `stall_cnt_clr`  in  1  synchronous clear of the stall counter.
- `source_not_ready`  out  1  combinational hazard hold to decode.
- `issue`  out  1  combinational; the uop is accepted this cycle.
- `busy_vec`  out  `NUM_REGS`  registered; bit i is set when pend[i]≠0.
- `drained`  out  1  registered single-cycle pulse when the DRAIN state exits.
- `wb_underflow`  out  1  sticky error flag.
- `stall_cycles`  out  `STALL_CNT_WIDTH`  saturating hazard-stall count.

## Operation
- **Per-register counter.** Each register has a counter `pend[i]`. Register x0 is never tracked: `pend[0]` stays 0, and x0 destinations and writebacks are ignored.
- **Source hazard.** `hazard_src` is true when (`dec_rs1_valid` and `pend[rs1]`≠0) or (`dec_rs2_valid` and `pend[rs2]`≠0).
  - With `WB_BYPASS`=1, a source whose `pend` equals 1 and that matches (`wb_valid`, `wb_rd`) in the same cycle is not a hazard.
- **Destination saturation.** `hazard_sat` is true when `dec_rd_valid`, rd≠0, and `pend[rd]` is at its maximum.
- **Hold output.** `source_not_ready` = `dec_valid` & (`hazard_src` | `hazard_sat` | state==DRAIN).
- **Issue.** `issue` = `dec_valid` & ~`source_not_ready` & ~`system_stall`.
- **Counter update.** On each edge:
  - `pend[rd]` increments when `issue` & `dec_rd_valid` & rd≠0.
  - `pend[wb_rd]` decrements when `wb_valid` & `wb_rd`≠0.
  - An increment and a decrement to the same register in the same cycle leave it unchanged.
  - A writeback to a register whose `pend` is already 0 is ignored, and it sets `wb_underflow`. Only reset clears `wb_underflow`.
- **FSM states:**
  - RUN → HOLD when `source_not_ready` is high.
  - HOLD → RUN when it is low.
  - Any state → DRAIN on `flush`.
  - DRAIN → RUN on the first cycle where all `pend` are 0 and `flush` is low; `drained` pulses on the following cycle.
  - A `flush` arriving during DRAIN keeps the FSM in DRAIN.
  - Writebacks continue to be accepted in DRAIN. Issue is blocked.
- **Stall counter.** `stall_cycles` increments on every cycle with `dec_valid` & `source_not_ready`. It saturates at all-ones. `stall_cnt_clr` takes priority over the increment.

## Timing
- **Reset values.** All `pend` = 0, `busy_vec` = 0, state = RUN, `drained` = 0, `wb_underflow` = 0, `stall_cycles` = 0.
  - While `dec_valid` is 0, `source_not_ready` and `issue` are 0.
- **Combinational outputs.** `source_not_ready` and `issue` are valid in the same cycle as the decode outputs. There are no flops on this path.
- **Scoreboard latency.** An issue at edge N makes `busy_vec[rd]` = 1 after edge N. A dependent uop presented in cycle N+1 stalls.
- **Writeback latency.** A writeback at cycle N releases a dependent uop:
  - in cycle N when `WB_BYPASS`=1;
  - in cycle N+1 otherwise.
- **Flush timing.** A `flush` in cycle N blocks issue from cycle N+1. A same-cycle `issue` in cycle N is still counted.
- **Reset mid-operation.** An asynchronous assert clears all state immediately. Outputs reflect the reset values while `reset` is low.

## Structure
- The shared package holds:
  - FSM state encoding (RUN=2'd0, HOLD=2'd1, DRAIN=2'd2);
  - the `REG_ADDR_WIDTH` and `NUM_REGS` constants, already defined in the system parameter header.
- One sub-module, `pend_counter`: a single-register up/down saturating counter with inc/dec/underflow. It is instantiated `NUM_REGS`-1 times in a generate loop.
- The hazard compare and FSM stay in the top level.

## Test plan
- **Back-to-back RAW.** Issue uop writing x5, then next cycle a uop reading x5 → `source_not_ready`=1 and `issue`=0. `wb_valid`, `wb_rd`=5 in cycle 3 → `issue`=1 in cycle 3 (bypass) and `busy_vec[5]`=0 after the edge.
- **x0 destination.** Issue with rd=0 → `busy_vec`=0. A reader of x0 is never stalled.
- **Saturation.** Issue 3 writes to x7 with `PEND_WIDTH`=2 → the 4th write to x7 stalls. One writeback to x7 → the 4th issues the next cycle.
- **Simultaneous events.**
  - Issue rd=9 and writeback x9 in the same cycle with `pend[9]`=1 → `pend[9]` stays 1.
  - Writeback x12 with `pend`=0 → `wb_underflow`=1 and stays sticky.
- **Flush/drain.** `pend[3]`=1, `pend[4]`=2, pulse `flush` → `issue` is blocked. After 3 writebacks → state RUN, `drained` pulses once.
- **Stall counter and reset.**
  - Hold a RAW stall for 10 cycles → `stall_cycles`=10.
  - Assert `stall_cnt_clr` → 0.
  - Assert `reset` mid-stall → all outputs return to their reset values asynchronously.
